// File: rtl/mux_sched_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin mux scheduler.
package mux_sched_pkg;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned TEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating-priority picker: first set req bit searching upward from last+1, wrapping.
import mux_sched_pkg::*;

module mux_rr_pick (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] index,
    output logic             any
);

    logic [SEL_W-1:0] w_cand;
    logic             w_found;

    // Scan offsets 1..NREQ from last; 4-bit addition wraps modulo 16, so offset 16 lands on last itself.
    always_comb begin
        index   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        any     = |req;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = last + SEL_W'(k);
            if (!w_found && req[w_cand]) begin
                index   = w_cand;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// 16:1 data mux with round-robin grant scheduler (IDLE -> BUSY -> GAP).
// Optional tenure limit enabled by defining MUX_SCHED_TIMEOUT_EN.
import mux_sched_pkg::*;

module mux16_rr_sched #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    input  logic [NREQ-1:0]  in,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic             out,
    output logic             timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("mux16_rr_sched: HOLD_MAX must be within 1..255");
    end

    sched_state_t     r_state, w_state_nx;
    logic [SEL_W-1:0] r_sel, w_sel_nx;
    logic [NREQ-1:0]  r_gnt, w_gnt_nx;
    logic             r_gnt_valid, w_valid_nx;
    logic [SEL_W-1:0] r_last, w_last_nx;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_expire;
    logic             w_release;
    logic             w_timeout_nx;

    mux_rr_pick u_pick (
        .req   (req),
        .last  (r_last),
        .index (w_pick_idx),
        .any   (w_pick_any)
    );

`ifdef MUX_SCHED_TIMEOUT_EN
    logic [TEN_W-1:0] r_ten, w_ten_nx;
    logic             r_timeout;

    // Tenure expires during the HOLD_MAX-th BUSY cycle (counter reads HOLD_MAX-1 then).
    always_comb begin
        w_expire = (32'(r_ten) + 32'd1) >= 32'(HOLD_MAX);
    end

    // Tenure counter and timeout pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ten     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_ten     <= w_ten_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign timeout = r_timeout;
`else
    // No tenure limit: grant persists until done or request drop.
    always_comb begin
        w_expire = 1'b0;
    end

    assign timeout = 1'b0;
`endif

    assign w_release = done | ~req[r_sel] | w_expire;

    // Next-state and registered-output computation.
    always_comb begin
        w_state_nx   = r_state;
        w_sel_nx     = r_sel;
        w_gnt_nx     = r_gnt;
        w_valid_nx   = r_gnt_valid;
        w_last_nx    = r_last;
        w_timeout_nx = 1'b0;
`ifdef MUX_SCHED_TIMEOUT_EN
        w_ten_nx     = r_ten;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nx = ST_BUSY;
                    w_sel_nx   = w_pick_idx;
                    w_gnt_nx   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
                    w_valid_nx = 1'b1;
`ifdef MUX_SCHED_TIMEOUT_EN
                    w_ten_nx   = '0;
`endif
                end
            end
            ST_BUSY: begin
`ifdef MUX_SCHED_TIMEOUT_EN
                if (r_ten != '1) begin
                    w_ten_nx = r_ten + TEN_W'(1);
                end
`endif
                if (w_release) begin
                    w_state_nx   = ST_GAP;
                    w_gnt_nx     = '0;
                    w_valid_nx   = 1'b0;
                    w_last_nx    = r_sel;
                    w_timeout_nx = w_expire & ~done;
                end
            end
            ST_GAP: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = '0;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers; reset mid-grant drops the grant with no GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_last      <= SEL_W'(NREQ - 1);
        end else begin
            r_state     <= w_state_nx;
            r_sel       <= w_sel_nx;
            r_gnt       <= w_gnt_nx;
            r_gnt_valid <= w_valid_nx;
            r_last      <= w_last_nx;
        end
    end

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign out       = r_gnt_valid ? in[r_sel] : 1'b0;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed testbench for mux16_rr_sched (HOLD_MAX = 4; timeout section depends on MUX_SCHED_TIMEOUT_EN).
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] in;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic        out;
    logic        timeout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mux16_rr_sched #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .in        (in),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .out       (out),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] eg, input logic [3:0] es,
                             input logic ev);
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".sel"}, {12'd0, sel}, {12'd0, es});
        chk({tag, ".valid"}, {15'd0, gnt_valid}, {15'd0, ev});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"}, gnt, 16'h0000);
        chk({tag, ".valid"}, {15'd0, gnt_valid}, 16'h0000);
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0; in = '0;
        tick(); tick();
        // reset state
        chk_state("rst", 16'h0000, 4'd0, 1'b0);
        chk("rst.out", {15'd0, out}, 16'h0000);
        chk("rst.timeout", {15'd0, timeout}, 16'h0000);
        rst = 1'b0;
        tick();
        chk_state("idle0", 16'h0000, 4'd0, 1'b0);

        // done in IDLE with no requests is ignored
        done = 1'b1;
        tick();
        chk_state("done_idle", 16'h0000, 4'd0, 1'b0);
        chk("done_idle.out", {15'd0, out}, 16'h0000);
        done = 1'b0;
        tick();
        chk_state("done_idle2", 16'h0000, 4'd0, 1'b0);

        // first grant to requester 0 with one-cycle latency; data passes through
        req = 16'h0001; in = 16'h0001;
        tick();
        chk_state("g0", 16'h0001, 4'd0, 1'b1);
        chk("g0.out", {15'd0, out}, 16'h0001);
        in = 16'h0000;
        #1;
        chk("g0.out_low", {15'd0, out}, 16'h0000);

        // restart from reset so the search starts at 0 again
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;

        // round robin 0 -> 8 -> 15 -> 0 with done pulsed in each grant
        req = 16'h8101;
        tick();
        chk_state("rr0", 16'h0001, 4'd0, 1'b1);
        done = 1'b1; tick(); done = 1'b0;
        chk_idle("rr0.gap");
        tick();
        chk_idle("rr0.idle");
        tick();
        chk_state("rr8", 16'h0100, 4'd8, 1'b1);
        done = 1'b1; tick(); done = 1'b0;
        chk_idle("rr8.gap");
        tick(); tick();
        chk_state("rr15", 16'h8000, 4'd15, 1'b1);
        done = 1'b1; tick(); done = 1'b0;
        chk_idle("rr15.gap");
        tick(); tick();
        chk_state("rr0b", 16'h0001, 4'd0, 1'b1);
        done = 1'b1; req = '0; tick(); done = 1'b0;
        chk_idle("rr0b.gap");
        tick();

        // last = 0: grant to 3, hold stable under other changes, release on req drop
        req = 16'h0028;
        tick();
        chk_state("g3", 16'h0008, 4'd3, 1'b1);
        req = 16'h002B;
        tick();
        chk_state("g3.hold", 16'h0008, 4'd3, 1'b1);
        req = 16'h0022;
        tick();
        chk_idle("g3.drop_gap");
        tick(); tick();
        chk_state("g5", 16'h0020, 4'd5, 1'b1);
        req = '0;
        tick();
        chk_idle("g5.gap");
        tick();

        // last = 5: req 2 wraps around
        req = 16'h0004;
        tick();
        chk_state("g2", 16'h0004, 4'd2, 1'b1);
`ifdef MUX_SCHED_TIMEOUT_EN
        chk("g2.to0", {15'd0, timeout}, 16'h0000);
        tick(); tick(); tick();
        chk_state("g2.busy4", 16'h0004, 4'd2, 1'b1);
        tick();
        chk_idle("g2.revoke");
        chk("g2.to_pulse", {15'd0, timeout}, 16'h0001);
        tick();
        chk("g2.to_clear", {15'd0, timeout}, 16'h0000);
        tick();
        chk_state("g2.regrant", 16'h0004, 4'd2, 1'b1);
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_idle("g2.done_expire");
        chk("g2.done_expire_to", {15'd0, timeout}, 16'h0000);
`else
        tick(); tick(); tick(); tick(); tick(); tick();
        chk_state("g2.held", 16'h0004, 4'd2, 1'b1);
        chk("g2.no_to", {15'd0, timeout}, 16'h0000);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_idle("g2.done");
`endif
        req = '0;
        tick(); tick();

        // last = 2: grant to 9, then asynchronous reset mid-grant
        req = 16'h0200; in = 16'h0200;
        tick();
        chk_state("g9", 16'h0200, 4'd9, 1'b1);
        chk("g9.out", {15'd0, out}, 16'h0001);
        rst = 1'b1;
        #1;
        chk_state("g9.async_rst", 16'h0000, 4'd0, 1'b0);
        chk("g9.rst_out", {15'd0, out}, 16'h0000);
        req = 16'h0201;
        tick();
        rst = 1'b0;
        tick();
        chk_state("post_rst", 16'h0001, 4'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux16_rr_sched.md
MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, meaning max grant tenure in cycles (1..255); used only when MUX_SCHED_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port req  input  16  per-requester request, bit i = requester i.
REQ-005 SHALL have port done  input  1  release strobe from current grantee.
REQ-006 SHALL have port in  input  16  data lines shared through the 16:1 mux.
REQ-007 SHALL have port sel  output  4  registered mux select = index of current grantee.
REQ-008 SHALL have port gnt  output  16  registered one-hot grant, all-zero when idle.
REQ-009 SHALL have port gnt_valid  output  1  high while a grant is held.
REQ-010 SHALL have port out  output  1  in[sel] when gnt_valid, else 0 (combinational from registered sel).
REQ-011 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by tenure limit.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, GAP.
- IDLE: req != 0 -> BUSY next edge; else stay.
- BUSY: release condition -> GAP; else stay.
- GAP: one dead cycle, gnt = 0, then IDLE.
REQ-013 SHALL pick, in IDLE, the first set req bit searching upward from (last+1) mod 16, wrapping; last = index of previous grantee, reset value 15 (first search starts at 0).
REQ-014 SHALL assert gnt, sel, gnt_valid on the edge after req observed in IDLE (latency 1 cycle).
REQ-015 SHALL hold sel and gnt stable throughout BUSY regardless of other req changes.
REQ-016 SHALL release in BUSY when done = 1, or req[sel] = 0, or (with timeout) tenure count reaches HOLD_MAX; release takes effect next edge (gnt = 0 in GAP).
REQ-017 SHALL update last = sel on the release edge.
REQ-018 SHALL ignore done outside BUSY.
REQ-019 SHALL, when done and tenure expiry coincide, treat release as normal (timeout stays 0).
REQ-020 SHALL give a requester holding req continuously a new grant only after all other asserted requesters (fairness within 16 grants).
REQ-021 SHALL keep tenure counter 8 bits wide, cleared on grant, incremented each BUSY cycle, saturating.

Reset
REQ-022 SHALL, on rst = 1 asynchronously: state = IDLE, sel = 0, gnt = 0, gnt_valid = 0, timeout = 0, last = 15, tenure = 0; out consequently 0.
REQ-023 SHALL, on reset mid-BUSY, drop grant immediately without a GAP cycle; first post-reset search starts at 0.

Configuration
REQ-024 SHALL gate the tenure limit with macro MUX_SCHED_TIMEOUT_EN: defined -> REQ-016 expiry and timeout pulse active; undefined -> no counter, timeout tied 0, grant held until done or req drop.

Structure
REQ-025 SHALL place in shared package mux_sched_pkg: NREQ = 16, SEL_W = 4, FSM state encoding, tenure counter width 8.
REQ-026 SHALL implement the rotating priority search as sub-module mux_rr_pick (inputs req, last; outputs index, any), purely combinational.

Verification
REQ-027 SHALL cover: reset, then req = 16'h0001 -> next cycle gnt = 16'h0001, sel = 0, gnt_valid = 1; in = 16'h0001 -> out = 1.
REQ-028 SHALL cover: req = 16'h8101 held, done pulsed each BUSY -> grant order 0, 8, 15, 0 with one GAP cycle (gnt = 0) between each.
REQ-029 SHALL cover: grant to 3, req[3] dropped -> GAP next cycle, following grant to next higher asserted index.
REQ-030 SHALL cover, with MUX_SCHED_TIMEOUT_EN and HOLD_MAX = 4: req = 16'h0004 held, no done -> grant revoked after 4 BUSY cycles, timeout pulses once, regranted to 2 after GAP.
REQ-031 SHALL cover: rst asserted mid-BUSY with sel = 9 -> gnt = 0, sel = 0, gnt_valid = 0 immediately; after release with req = 16'h0201, grant goes to 0.
REQ-032 SHALL cover: done asserted in IDLE with req = 0 -> no state change, all outputs stay 0.
